// File: rtl/store_merge_unit.sv
// Store-path merge unit: word stores write directly, while byte and halfword stores read-modify-write the target word.
// Define STORE_MISALIGN_TRAP_EN to trap misaligned half/word stores (done+exc, no memory access).
module store_merge_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] merged_data,
  output logic              done,
  output logic              exc,
  output logic              busy
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  localparam logic [1:0] SZ_NOP  = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_WRITE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [1:0]          r_size;
  logic [OFF_W-1:0]    r_off;
  logic [15:0]         r_data_lo;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [DATA_W-1:0]   r_merged;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic                r_done;
  logic                r_exc;
  logic                r_busy;
  logic                w_accept;
  logic                w_misalign;
  logic [DATA_W-1:0]   w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

`ifdef STORE_MISALIGN_TRAP_EN
  assign w_misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[OFF_W-1:0] != '0));
`else
  assign w_misalign = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          if (w_misalign || (req_size == SZ_NOP)) w_next = S_DONE;
          else if (req_size == SZ_WORD)           w_next = S_WRITE;
          else                                     w_next = S_READ;
        end
      end
      S_READ:  w_next = S_WAIT;
      S_WAIT:  if (r_wait_cnt == CNT_W'(MEM_LAT - 1)) w_next = S_WRITE;
      S_WRITE: w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Little-endian lane merge of the latched source into the read word
  always_comb begin
    w_merged = mem_rdata;
    for (int unsigned i = 0; i < NB; i++) begin
      if ((r_size == SZ_BYTE) && (r_off == OFF_W'(i))) begin
        w_merged[8*i +: 8] = r_data_lo[7:0];
      end else if ((r_size == SZ_HALF) && (r_off[OFF_W-1:1] == (OFF_W-1)'(i >> 1))) begin
        w_merged[8*i +: 8] = r_data_lo[8*(i%2) +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
      r_size     <= SZ_NOP;
      r_off      <= '0;
      r_data_lo  <= '0;
    end else begin
      r_wait_cnt <= (r_state == S_WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
      if (w_accept) begin
        r_size    <= req_size;
        r_off     <= req_addr[OFF_W-1:0];
        r_data_lo <= req_data[15:0];
      end
    end
  end

  // Outputs are registered from the next state so strobes line up with their state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_done      <= 1'b0;
      r_exc       <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_merged    <= '0;
    end else begin
      r_mem_rd <= (w_next == S_READ);
      r_mem_wr <= (w_next == S_WRITE);
      r_done   <= (w_next == S_DONE);
      r_exc    <= w_accept && w_misalign;
      r_busy   <= (w_next != S_IDLE);
      if (w_accept) r_mem_addr <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
      if ((r_state == S_IDLE) && (w_next == S_WRITE)) begin
        r_mem_wdata <= req_data;
        r_merged    <= req_data;
      end else if ((r_state == S_WAIT) && (w_next == S_WRITE)) begin
        r_mem_wdata <= w_merged;
        r_merged    <= w_merged;
      end
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign mem_wr      = r_mem_wr;
  assign mem_wdata   = r_mem_wdata;
  assign merged_data = r_merged;
  assign done        = r_done;
  assign exc         = r_exc;
  assign busy        = r_busy;

endmodule
